// File: rtl/dogbattle_arena.sv
// rtl/dogbattle_arena.sv - dogbattle battle engine: FSM, per-dog HP and cooldowns, winner/draw resolution.
// Optional critical hits are enabled with the DOGBATTLE_CRIT_EN macro.
module dogbattle_arena #(
    parameter int NUM_DOGS = 2,
    parameter int HP_W     = 4,
    parameter int MAX_HP   = 15,
    parameter int COOLDOWN = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     start_i,
    input  logic [NUM_DOGS-1:0]      atk_i,
    output logic [NUM_DOGS*HP_W-1:0] hp_o,
    output logic [NUM_DOGS-1:0]      alive_o,
    output logic [1:0]               state_o,
    output logic [1:0]               winner_o,
    output logic                     done_o,
    output logic                     draw_o
);
    localparam int DW = HP_W + 3;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FIGHT = 2'b01,
        OVER  = 2'b10
    } state_t;

    state_t                           state_q;
    logic [NUM_DOGS-1:0][HP_W-1:0]    hp_q;
    logic [NUM_DOGS-1:0][3:0]         cd_q;
    logic [1:0]                       winner_q;
    logic                             done_q;
    logic                             draw_q;

    logic [NUM_DOGS-1:0]              alive;
    logic [NUM_DOGS-1:0]              accept;
    logic [NUM_DOGS-1:0][DW-1:0]      dmg;
    logic [NUM_DOGS-1:0][HP_W-1:0]    hp_nxt;
    logic [NUM_DOGS-1:0][3:0]         cd_nxt;
    logic [DW-1:0]                    hit;
    logic [DW-1:0]                    hp_ext;
    logic [2:0]                       alive_cnt;
    logic [1:0]                       win_idx;
    logic                             found;
    int                               tgt;
    logic                             crit;

`ifdef DOGBATTLE_CRIT_EN
    logic [7:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= 8'h01;
        end else if (ena) begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign crit = (lfsr_q[2:0] == 3'b000);
`else
    assign crit = 1'b0;
`endif

    assign hit = crit ? DW'(2) : DW'(1);

    always_comb begin
        for (int i = 0; i < NUM_DOGS; i++) begin
            alive[i] = |hp_q[i];
        end
    end

    // Targets use the pre-update alive vector, so every accepted hit (even from a dog dying now) lands.
    always_comb begin
        dmg    = '0;
        accept = '0;
        found  = 1'b0;
        tgt    = 0;
        for (int i = 0; i < NUM_DOGS; i++) begin
            accept[i] = (state_q == FIGHT) && atk_i[i] && alive[i] && (cd_q[i] == 4'd0);
            found = 1'b0;
            for (int k = 1; k < NUM_DOGS; k++) begin
                tgt = (i + k) % NUM_DOGS;
                if (accept[i] && !found && alive[tgt]) begin
                    dmg[tgt] = dmg[tgt] + hit;
                    found    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        alive_cnt = 3'd0;
        win_idx   = 2'd0;
        hp_ext    = '0;
        for (int i = 0; i < NUM_DOGS; i++) begin
            hp_ext    = DW'(hp_q[i]);
            hp_nxt[i] = (hp_ext > dmg[i]) ? HP_W'(hp_ext - dmg[i]) : '0;
            if (hp_nxt[i] != '0) begin
                alive_cnt = alive_cnt + 3'd1;
                win_idx   = 2'(i);
            end
            if (accept[i]) begin
                cd_nxt[i] = 4'(COOLDOWN);
            end else if (cd_q[i] != 4'd0) begin
                cd_nxt[i] = cd_q[i] - 4'd1;
            end else begin
                cd_nxt[i] = 4'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            hp_q     <= {NUM_DOGS{HP_W'(MAX_HP)}};
            cd_q     <= '0;
            winner_q <= 2'd0;
            done_q   <= 1'b0;
            draw_q   <= 1'b0;
        end else if (ena) begin
            case (state_q)
                FIGHT: begin
                    hp_q <= hp_nxt;
                    cd_q <= cd_nxt;
                    if (alive_cnt <= 3'd1) begin
                        state_q  <= OVER;
                        done_q   <= 1'b1;
                        draw_q   <= (alive_cnt == 3'd0);
                        winner_q <= (alive_cnt == 3'd1) ? win_idx : 2'd0;
                    end
                end
                default: begin
                    if (start_i) begin
                        state_q  <= FIGHT;
                        hp_q     <= {NUM_DOGS{HP_W'(MAX_HP)}};
                        cd_q     <= '0;
                        winner_q <= 2'd0;
                        done_q   <= 1'b0;
                        draw_q   <= 1'b0;
                    end else begin
                        cd_q <= cd_nxt;
                    end
                end
            endcase
        end
    end

    assign hp_o     = hp_q;
    assign alive_o  = alive;
    assign state_o  = state_q;
    assign winner_o = winner_q;
    assign done_o   = done_q;
    assign draw_o   = draw_q;
endmodule

// File: doc/dogbattle_arena.md
# dogbattle_arena

Parametrised battle-engine core for the dogbattle TinyTapeout design, generalising the fixed two-dog game to 2–4 dogs with per-dog hit points and attack cooldowns. It sits below the `tt_um_SophusAndreassen_dogbattle` top level. The top level maps `ui_in` bits to start and attack buttons and drives `uo_out`/`uio_out` from the status outputs here. All game state lives in this block: FSM, HP counters, cooldown counters, winner/draw resolution.

## Interface
- `NUM_DOGS`, 2: number of dogs, legal 2..4.
- `HP_W`, 4: width of each HP counter.
- `MAX_HP`, 15: starting HP per dog, 1..2^HP_W-1.
- `COOLDOWN`, 3: idle cycles forced after an accepted attack, 0..15.
- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  reset, synchronous, active-low.
- `ena`  in  1  enable; when low, all registers hold.
- `start_i`  in  1  start/restart game (level, sampled per cycle).
- `atk_i`  in  NUM_DOGS  attack request, bit i = dog i.
- `hp_o`  out  NUM_DOGS*HP_W  packed HP; dog i at `[i*HP_W +: HP_W]`.
- `alive_o`  out  NUM_DOGS  bit i set while dog i HP > 0.
- `state_o`  out  2  00 IDLE, 01 FIGHT, 10 OVER.
- `winner_o`  out  2  index of sole survivor; valid when `done_o & ~draw_o`.
- `done_o`  out  1  high in OVER.
- `draw_o`  out  1  high in OVER when no dog survived.

## Operation
- Reset values, and all registers on any clk edge with `rst_n`=0 regardless of `ena`: state IDLE, every HP = MAX_HP, `alive_o` all ones, cooldowns 0, `winner_o`=0, `done_o`=0, `draw_o`=0. Reset mid-fight discards the game.
- IDLE: `start_i`=1 → FIGHT. HP is reloaded to MAX_HP and cooldowns are cleared on that same edge.
- FIGHT: attack by dog i is accepted when `atk_i[i]`=1, dog i is alive, and cooldown[i]=0.
- Target of dog i is the next alive dog clockwise: the lowest j in i+1, i+2, … (mod NUM_DOGS) with alive[j]=1. This uses the alive vector before this cycle's update.
- All accepted attacks in a cycle apply simultaneously. Damage to a dog is the sum of hits on it. HP saturates at 0; it never wraps.
- A dog killed this cycle still delivers its own accepted attack this cycle.
- An accepted attack loads cooldown[i]=COOLDOWN. A nonzero cooldown decrements by 1 per enabled cycle. `atk_i` is ignored while the cooldown is nonzero.
- `start_i` is ignored in FIGHT.
- End of game: if the post-update alive count ≤ 1, FIGHT → OVER on the same edge.
  - Count = 1: `winner_o` = the surviving index, `draw_o`=0.
  - Count = 0: `draw_o`=1, `winner_o`=0.
- OVER: outputs hold. `start_i`=1 → FIGHT with HP reloaded, cooldowns cleared, and `winner_o`/`draw_o`/`done_o` cleared on the same edge.
- `ena`=0: no register changes; `atk_i` and `start_i` are ignored in that cycle.

## Timing
- Attack sampled on edge N → `hp_o`/`alive_o` updated and visible after edge N. Latency is 1 cycle.
- With COOLDOWN=C, the next attack from the same dog is accepted no earlier than edge N+C+1. C=0 allows an attack every cycle.
- `state_o`, `done_o`, `winner_o` and `draw_o` change on the same edge as the killing HP update; there is no extra resolve cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `DOGBATTLE_CRIT_EN` defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) is seeded to 0x01 at reset and advances each enabled cycle in any state.
  - Each accepted attack is a critical hit (damage 2 instead of 1) when `lfsr[2:0]`=000 on that cycle. All attackers that cycle share the same crit decision.
- Not defined: no LFSR is instantiated, and damage is always 1 per hit.

## Test plan
- Reset/idle: hold `rst_n`=0 for 2 cycles, then release → `state_o`=00, each HP=15, `alive_o`=all ones, `done_o`=0. Attacks in IDLE leave HP at 15.
- Basic duel (NUM_DOGS=2, MAX_HP=3, COOLDOWN=0): start, then hold `atk_i`=01 → dog1 HP 2,1,0 on three consecutive edges. On the third edge `state_o`=10, `winner_o`=0, `draw_o`=0.
- Cooldown (COOLDOWN=2): hold `atk_i`=01 continuously → hits are accepted on edges 1, 4 and 7 only. Dog1 HP 15→14→13→12.
- Simultaneous kill: NUM_DOGS=2, both dogs at HP 1, `atk_i`=11 on one edge → both HP=0, `draw_o`=1, `done_o`=1.
- Clockwise retarget (NUM_DOGS=3): kill dog1, then dog0 attacks → dog2 loses HP. Dog2 attacking hits dog0. Killing dog2 → `winner_o`=0.
- Enable and restart: `ena`=0 with attacks asserted → no HP change. In OVER, pulse `start_i` → `state_o`=01, all HP=MAX_HP, `done_o`=0 after one edge.
